// File: rtl/jedro_1_regfile_arbiter.sv
// Round-robin arbiter sharing a single-port register file between decode (A) and
// writeback (B), with a soft-clear sequencer that sweeps x1..x(N-1) to zero.
module jedro_1_regfile_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic                  a_we_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_wdata_i,
  output logic                  a_rvalid_o,
  output logic [DATA_WIDTH-1:0] a_rdata_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic                  b_we_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_wdata_i,
  output logic                  b_rvalid_o,
  output logic [DATA_WIDTH-1:0] b_rdata_o,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  rf_we_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(NREGS - 2);

  logic [0:0]            state_q, state_d;
  logic                  prio_q, prio_d;  // 0 = A wins a tie, 1 = B wins
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  pend_a_q, pend_a_zero_q, pend_b_q, pend_b_zero_q;
  logic [DATA_WIDTH-1:0] rdata_a_q, rdata_b_q;
  logic                  grant_a, grant_b;
  logic [DATA_WIDTH-1:0] a_resp, b_resp;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rstn_i && state_q == ST_IDLE && !clear_i) begin
      if (a_valid_i && (!b_valid_i || !prio_q)) grant_a = 1'b1;
      else if (b_valid_i)                       grant_b = 1'b1;
    end
  end

  // Register file port mux: sweep first, then the granted requester.
  always_comb begin
    rf_addr_o = '0;
    rf_data_o = '0;
    rf_we_o   = 1'b0;
    if (!rstn_i && state_q == ST_CLEAR) begin
      rf_addr_o = clr_cnt_q + 1'b1;
      rf_we_o   = 1'b1;
    end else if (grant_a) begin
      rf_addr_o = a_addr_i;
      rf_data_o = a_wdata_i;
      rf_we_o   = a_we_i && (a_addr_i != '0);
    end else if (grant_b) begin
      rf_addr_o = b_addr_i;
      rf_data_o = b_wdata_i;
      rf_we_o   = b_we_i && (b_addr_i != '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    prio_d    = prio_q;
    if (state_q == ST_IDLE) begin
      if (clear_i) state_d = ST_CLEAR;
      if ((grant_a || grant_b) && a_valid_i && b_valid_i) prio_d = ~prio_q;
    end else if (clr_cnt_q == CLR_LAST) begin
      clr_cnt_d = '0;
      state_d   = ST_IDLE;
    end else begin
      clr_cnt_d = clr_cnt_q + 1'b1;
    end
  end

  // x0 reads return zero regardless of what the register file holds.
  assign a_resp = pend_a_zero_q ? '0 : rf_data_i;
  assign b_resp = pend_b_zero_q ? '0 : rf_data_i;

  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign a_rvalid_o = pend_a_q;
  assign b_rvalid_o = pend_b_q;
  assign a_rdata_o  = pend_a_q ? a_resp : rdata_a_q;
  assign b_rdata_o  = pend_b_q ? b_resp : rdata_b_q;
  assign busy_o     = !rstn_i && (state_q == ST_CLEAR);

  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q       <= ST_IDLE;
      prio_q        <= 1'b0;
      clr_cnt_q     <= '0;
      pend_a_q      <= 1'b0;
      pend_a_zero_q <= 1'b0;
      pend_b_q      <= 1'b0;
      pend_b_zero_q <= 1'b0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      clr_cnt_q     <= clr_cnt_d;
      pend_a_q      <= grant_a && !a_we_i;
      pend_a_zero_q <= (a_addr_i == '0);
      pend_b_q      <= grant_b && !b_we_i;
      pend_b_zero_q <= (b_addr_i == '0);
      if (pend_a_q) rdata_a_q <= a_resp;
      if (pend_b_q) rdata_b_q <= b_resp;
    end
  end

endmodule

// File: tb/tb_jedro_1_regfile_arbiter.sv
// Directed bench for jedro_1_regfile_arbiter with a behavioural single-port
// register file (registered read) attached to the rf_* port.
module tb_jedro_1_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i, clear_i, busy_o;
  logic        a_valid_i, a_ready_o, a_we_i, a_rvalid_o;
  logic [4:0]  a_addr_i;
  logic [31:0] a_wdata_i, a_rdata_o;
  logic        b_valid_i, b_ready_o, b_we_i, b_rvalid_o;
  logic [4:0]  b_addr_i;
  logic [31:0] b_wdata_i, b_rdata_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_o, rf_data_i;
  logic        rf_we_o;
  logic        rf_init;
  logic [31:0] mem [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jedro_1_regfile_arbiter dut (
    .clk_i(clk), .rstn_i(rstn_i), .clear_i(clear_i), .busy_o(busy_o),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_we_i(a_we_i),
    .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_we_i(b_we_i),
    .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o),
    .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_we_o(rf_we_o),
    .rf_data_i(rf_data_i)
  );

  // Register file model: read-first, data valid one cycle after the address.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else begin
      rf_data_i <= mem[rf_addr_o];
      if (rf_we_o) mem[rf_addr_o] <= rf_data_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_check();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: reset held with every input active
    rstn_i = 1'b1; rf_init = 1'b1; clear_i = 1'b1;
    a_valid_i = 1'b1; a_we_i = 1'b1; a_addr_i = 5'd5; a_wdata_i = 32'hFFFF_FFFF;
    b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 5'd6; b_wdata_i = 32'hFFFF_FFFF;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      to_check();
      chk("rst_a_ready", {31'b0, a_ready_o}, 32'd0);
      chk("rst_b_ready", {31'b0, b_ready_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_rf_we", {31'b0, rf_we_o}, 32'd0);
      chk("rst_rf_addr", {27'b0, rf_addr_o}, 32'd0);
      chk("rst_rf_data", rf_data_o, 32'd0);
      chk("rst_a_rvalid", {31'b0, a_rvalid_o}, 32'd0);
      chk("rst_a_rdata", a_rdata_o, 32'd0);
      chk("rst_b_rdata", b_rdata_o, 32'd0);
      next_cycle();
    end
    rstn_i = 1'b0; rf_init = 1'b0; clear_i = 1'b0;
    a_valid_i = 1'b0; a_we_i = 1'b0; b_valid_i = 1'b0; b_we_i = 1'b0;
    next_cycle();

    // Test 2: B writes x5, then A reads it back
    b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 5'd5; b_wdata_i = 32'hDEAD_BEEF;
    to_check();
    chk("t2_b_ready", {31'b0, b_ready_o}, 32'd1);
    chk("t2_rf_we", {31'b0, rf_we_o}, 32'd1);
    chk("t2_rf_addr", {27'b0, rf_addr_o}, 32'd5);
    chk("t2_rf_data", rf_data_o, 32'hDEAD_BEEF);
    next_cycle();
    b_valid_i = 1'b0; b_we_i = 1'b0;
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 5'd5;
    to_check();
    chk("t2_a_ready", {31'b0, a_ready_o}, 32'd1);
    chk("t2_rd_rf_we", {31'b0, rf_we_o}, 32'd0);
    chk("t2_rd_addr", {27'b0, rf_addr_o}, 32'd5);
    chk("t2_a_rvalid_early", {31'b0, a_rvalid_o}, 32'd0);
    next_cycle();
    a_valid_i = 1'b0;
    to_check();
    chk("t2_a_rvalid", {31'b0, a_rvalid_o}, 32'd1);
    chk("t2_a_rdata", a_rdata_o, 32'hDEAD_BEEF);
    chk("t2_b_rvalid", {31'b0, b_rvalid_o}, 32'd0);
    next_cycle();
    to_check();
    chk("t2_a_rvalid_drop", {31'b0, a_rvalid_o}, 32'd0);
    chk("t2_a_rdata_hold", a_rdata_o, 32'hDEAD_BEEF);
    next_cycle();

    // Test 3: both ports read continuously, grants alternate A,B,A,B
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 5'd1;
    b_valid_i = 1'b1; b_we_i = 1'b0; b_addr_i = 5'd2;
    for (int c = 0; c < 4; c++) begin
      to_check();
      chk("t3_a_ready", {31'b0, a_ready_o}, (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_b_ready", {31'b0, b_ready_o}, (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_rf_addr", {27'b0, rf_addr_o}, (c % 2 == 0) ? 32'd1 : 32'd2);
      chk("t3_a_rvalid", {31'b0, a_rvalid_o}, (c % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_b_rvalid", {31'b0, b_rvalid_o}, (c == 2) ? 32'd1 : 32'd0);
      if (c % 2 == 1) chk("t3_a_rdata", a_rdata_o, 32'hA000_0001);
      if (c == 2)     chk("t3_b_rdata", b_rdata_o, 32'hA000_0002);
      next_cycle();
    end
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    to_check();
    chk("t3_b_rvalid_last", {31'b0, b_rvalid_o}, 32'd1);
    chk("t3_b_rdata_last", b_rdata_o, 32'hA000_0002);
    chk("t3_a_rvalid_last", {31'b0, a_rvalid_o}, 32'd0);
    next_cycle();

    // Test 4: x0 write suppressed, x0 read returns zero
    b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 5'd0; b_wdata_i = 32'h1234_5678;
    to_check();
    chk("t4_b_ready", {31'b0, b_ready_o}, 32'd1);
    chk("t4_rf_we", {31'b0, rf_we_o}, 32'd0);
    next_cycle();
    b_valid_i = 1'b0; b_we_i = 1'b0;
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 5'd0;
    to_check();
    chk("t4_a_ready", {31'b0, a_ready_o}, 32'd1);
    next_cycle();
    a_valid_i = 1'b0;
    to_check();
    chk("t4_a_rvalid", {31'b0, a_rvalid_o}, 32'd1);
    chk("t4_a_rdata", a_rdata_o, 32'd0);
    next_cycle();

    // Test 5: write x7, soft clear while A waits to read x7
    b_valid_i = 1'b1; b_we_i = 1'b1; b_addr_i = 5'd7; b_wdata_i = 32'h0000_0055;
    next_cycle();
    b_valid_i = 1'b0; b_we_i = 1'b0;
    clear_i = 1'b1; a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 5'd7;
    to_check();
    chk("t5_req_a_ready", {31'b0, a_ready_o}, 32'd0);
    chk("t5_req_busy", {31'b0, busy_o}, 32'd0);
    chk("t5_req_rf_we", {31'b0, rf_we_o}, 32'd0);
    next_cycle();
    clear_i = 1'b0;
    for (int c = 0; c < 31; c++) begin
      if (c == 5) clear_i = 1'b1;
      if (c == 6) clear_i = 1'b0;
      to_check();
      chk("t5_busy", {31'b0, busy_o}, 32'd1);
      chk("t5_rf_addr", {27'b0, rf_addr_o}, 32'(c + 1));
      chk("t5_rf_we", {31'b0, rf_we_o}, 32'd1);
      chk("t5_rf_data", rf_data_o, 32'd0);
      chk("t5_a_ready", {31'b0, a_ready_o}, 32'd0);
      next_cycle();
    end
    to_check();
    chk("t5_busy_done", {31'b0, busy_o}, 32'd0);
    chk("t5_a_ready_after", {31'b0, a_ready_o}, 32'd1);
    chk("t5_rd_addr", {27'b0, rf_addr_o}, 32'd7);
    next_cycle();
    a_valid_i = 1'b0;
    to_check();
    chk("t5_a_rvalid", {31'b0, a_rvalid_o}, 32'd1);
    chk("t5_a_rdata", a_rdata_o, 32'd0);
    next_cycle();

    // Test 6: reset in the 10th clear cycle aborts the sweep
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      to_check();
      chk("t6_busy", {31'b0, busy_o}, 32'd1);
      chk("t6_rf_addr", {27'b0, rf_addr_o}, 32'(c + 1));
      next_cycle();
    end
    rstn_i = 1'b1;
    next_cycle();
    rstn_i = 1'b0;
    to_check();
    chk("t6_busy_after", {31'b0, busy_o}, 32'd0);
    chk("t6_rf_we_after", {31'b0, rf_we_o}, 32'd0);
    chk("t6_rf_addr_after", {27'b0, rf_addr_o}, 32'd0);
    chk("t6_b_rdata_after", b_rdata_o, 32'd0);
    chk("t6_a_rvalid_after", {31'b0, a_rvalid_o}, 32'd0);
    next_cycle();
    a_valid_i = 1'b1; a_we_i = 1'b0; a_addr_i = 5'd3;
    to_check();
    chk("t6_idle_grant", {31'b0, a_ready_o}, 32'd1);
    chk("t6_idle_busy", {31'b0, busy_o}, 32'd0);
    next_cycle();
    a_valid_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
